// File: rtl/logic_preimage_finder.sv
// Exhaustive preimage search for E = C&D, F = ~((A&B)|C) | (C&D).
// Streams every {A,B,C,D} that hits the requested {E,F}, then pulses done.
module logic_preimage_finder #(
    parameter bit DESCEND     = 1'b0,
    parameter int MAX_MATCHES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] tgt,
    input  logic       abort,
    output logic       busy,
    output logic       m_valid,
    output logic [3:0] m_vec,
    input  logic       m_ready,
    output logic       done,
    output logic [4:0] match_cnt,
    output logic       none_found
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } state_t;

    localparam logic [3:0] FIRST   = DESCEND ? 4'd15 : 4'd0;
    localparam logic [3:0] LAST    = DESCEND ? 4'd0 : 4'd15;
    localparam logic [4:0] MAX_CNT = 5'(MAX_MATCHES);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] idx_step;
    logic [1:0] tgt_q;
    logic       hit;
    logic       at_last;
    logic [4:0] cnt_inc;

    function automatic logic [1:0] gate_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {c & d, ~((a & b) | c) | (c & d)};
    endfunction

    always_comb begin
        hit      = (gate_f(idx) == tgt_q);
        at_last  = (idx == LAST);
        idx_step = DESCEND ? idx - 4'd1 : idx + 4'd1;
        cnt_inc  = match_cnt + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            tgt_q      <= 2'd0;
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_vec      <= 4'd0;
            done       <= 1'b0;
            match_cnt  <= 5'd0;
            none_found <= 1'b0;
        end else begin
            done <= 1'b0;
            // abort beats start in IDLE and discards an unaccepted match
            if (abort) begin
                state   <= IDLE;
                busy    <= 1'b0;
                m_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            tgt_q     <= tgt;
                            idx       <= FIRST;
                            match_cnt <= 5'd0;
                            busy      <= 1'b1;
                            state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (hit) begin
                            m_vec   <= idx;
                            m_valid <= 1'b1;
                            state   <= EMIT;
                        end else if (at_last) begin
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx <= idx_step;
                        end
                    end
                    EMIT: begin
                        if (m_ready) begin
                            m_valid   <= 1'b0;
                            match_cnt <= cnt_inc;
                            if (at_last || cnt_inc == MAX_CNT) begin
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                idx   <= idx_step;
                                state <= SCAN;
                            end
                        end
                    end
                    DONE: begin
                        done       <= 1'b1;
                        none_found <= (match_cnt == 5'd0);
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_logic_preimage_finder.sv
// Bench for logic_preimage_finder: two instances (ascending/full and
// descending/limit 2) share stimulus and are checked against a table model.
module tb_logic_preimage_finder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       abort;
    logic       m_ready;
    logic [1:0] tgt;
    logic [1:0] busy;
    logic [1:0] m_valid;
    logic [1:0] done;
    logic [1:0] none_found;
    logic [3:0] m_vec [2];
    logic [4:0] match_cnt [2];

    logic_preimage_finder #(.DESCEND(1'b0), .MAX_MATCHES(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .tgt(tgt), .abort(abort),
        .busy(busy[0]), .m_valid(m_valid[0]), .m_vec(m_vec[0]),
        .m_ready(m_ready), .done(done[0]), .match_cnt(match_cnt[0]),
        .none_found(none_found[0])
    );

    logic_preimage_finder #(.DESCEND(1'b1), .MAX_MATCHES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .tgt(tgt), .abort(abort),
        .busy(busy[1]), .m_valid(m_valid[1]), .m_vec(m_vec[1]),
        .m_ready(m_ready), .done(done[1]), .match_cnt(match_cnt[1]),
        .none_found(none_found[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    int exp_v [2][16];
    int exp_n [2];
    int exp_last [2];
    int got_v [2][16];
    int acc [2];
    int done_cnt [2];
    int done_at [2];
    bit hold [2];
    int hold_vec [2];
    int cyc;
    int stall_left;
    bit stalled;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Matching vectors in scan order for both instances, from the gate equations.
    function automatic void build_ref(input logic [1:0] t);
        for (int d = 0; d < 2; d++) begin
            exp_n[d]    = 0;
            exp_last[d] = 15;
            for (int k = 0; k < 16; k++) begin
                int v, a, b, c, e, f, lim;
                v   = (d == 1) ? 15 - k : k;
                a   = (v >> 3) & 1;
                b   = (v >> 2) & 1;
                c   = (v >> 1) & 1;
                e   = c & (v & 1);
                f   = (1 - ((a & b) | c)) | e;
                lim = (d == 1) ? 2 : 16;
                if (exp_n[d] < lim && e * 2 + f == int'(t)) begin
                    exp_v[d][exp_n[d]] = v;
                    exp_n[d]++;
                    if (exp_n[d] == lim) exp_last[d] = k;
                end
            end
        end
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", tag, d), int'(busy[d]), 0);
            chk($sformatf("%s_valid%0d", tag, d), int'(m_valid[d]), 0);
            chk($sformatf("%s_vec%0d", tag, d), int'(m_vec[d]), 0);
            chk($sformatf("%s_done%0d", tag, d), int'(done[d]), 0);
            chk($sformatf("%s_cnt%0d", tag, d), int'(match_cnt[d]), 0);
            chk($sformatf("%s_none%0d", tag, d), int'(none_found[d]), 0);
        end
    endtask

    task automatic step_obs(input int mode);
        for (int d = 0; d < 2; d++) begin
            if (hold[d]) begin
                chk($sformatf("hold_valid%0d", d), int'(m_valid[d]), 1);
                chk($sformatf("hold_vec%0d", d), int'(m_vec[d]), hold_vec[d]);
            end
            if (m_valid[d]) chk($sformatf("busy_emit%0d", d), int'(busy[d]), 1);
            if (done[d]) begin
                done_cnt[d]++;
                if (done_cnt[d] == 1) done_at[d] = cyc;
                chk($sformatf("done_cnt%0d", d), int'(match_cnt[d]), acc[d]);
                chk($sformatf("done_none%0d", d), int'(none_found[d]),
                    int'(acc[d] == 0));
            end
        end
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (m_valid[0] && !stalled) begin
                    stalled    = 1'b1;
                    stall_left = 5;
                end
                m_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
        endcase
        for (int d = 0; d < 2; d++) begin
            if (m_valid[d] && m_ready) begin
                if (acc[d] < 16) got_v[d][acc[d]] = int'(m_vec[d]);
                acc[d]++;
            end
            hold[d]     = m_valid[d] && !m_ready;
            hold_vec[d] = int'(m_vec[d]);
        end
        tick();
        cyc++;
    endtask

    task automatic do_search(input logic [1:0] t, input int mode,
                             input int glitch_at);
        build_ref(t);
        for (int d = 0; d < 2; d++) begin
            acc[d]      = 0;
            done_cnt[d] = 0;
            done_at[d]  = -1;
            hold[d]     = 1'b0;
        end
        stalled    = 1'b0;
        stall_left = 0;
        tgt        = t;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        chk("busy_start0", int'(busy[0]), 1);
        chk("busy_start1", int'(busy[1]), 1);
        while (cyc < 400 && (done_cnt[0] == 0 || done_cnt[1] == 0)) begin
            if (cyc == glitch_at) begin
                start = 1'b1;
                tgt   = ~t;
            end else begin
                start = 1'b0;
            end
            step_obs(mode);
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) step_obs(mode);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("done_seen%0d", d), int'(done_cnt[d] > 0), 1);
            chk($sformatf("n_match%0d", d), acc[d], exp_n[d]);
            for (int i = 0; i < exp_n[d]; i++)
                if (i < acc[d])
                    chk($sformatf("vec%0d[%0d]", d, i), got_v[d][i], exp_v[d][i]);
            chk($sformatf("one_done%0d", d), done_cnt[d], 1);
            chk($sformatf("idle%0d", d), int'(busy[d]), 0);
            chk($sformatf("cnt_held%0d", d), int'(match_cnt[d]), exp_n[d]);
            chk($sformatf("none%0d", d), int'(none_found[d]), int'(exp_n[d] == 0));
            if (mode == 0)
                chk($sformatf("latency%0d", d), done_at[d],
                    exp_last[d] + exp_n[d] + 2);
        end
    endtask

    task automatic no_done_window(input string tag);
        int seen [2];
        seen[0] = 0;
        seen[1] = 0;
        for (int i = 0; i < 20; i++) begin
            for (int d = 0; d < 2; d++) if (done[d]) seen[d]++;
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_no_done%0d", tag, d), seen[d], 0);
            chk($sformatf("%s_busy%0d", tag, d), int'(busy[d]), 0);
        end
    endtask

    task automatic reset_mid_emit();
        int n;
        int i;
        build_ref(2'b01);
        tgt     = 2'b01;
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        i = 0;
        while (i < 40 && !(m_valid[0] && n == 1)) begin
            if (m_valid[0]) n++;
            tick();
            i++;
        end
        chk("rst_pre_valid", int'(m_valid[0]), 1);
        chk("rst_pre_vec", int'(m_vec[0]), exp_v[0][1]);
        m_ready = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_mid");
        no_done_window("rst_mid");
    endtask

    task automatic abort_mid_scan();
        int i;
        tgt     = 2'b01;
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        acc[0] = 0;
        acc[1] = 0;
        i = 0;
        while (i < 60 && acc[0] < 3) begin
            for (int d = 0; d < 2; d++) if (m_valid[d]) acc[d]++;
            tick();
            i++;
        end
        chk("abort_pre_busy", int'(busy[0]), 1);
        m_ready = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort_busy%0d", d), int'(busy[d]), 0);
            chk($sformatf("abort_valid%0d", d), int'(m_valid[d]), 0);
            chk($sformatf("abort_cnt%0d", d), int'(match_cnt[d]), acc[d]);
        end
        no_done_window("abort");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("start_abort_busy%0d", d), int'(busy[d]), 0);
            chk($sformatf("start_abort_cnt%0d", d), int'(match_cnt[d]), acc[d]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        m_ready = 1'b0;
        tgt     = 2'b00;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        do_search(2'b11, 0, -1);
        do_search(2'b10, 0, -1);
        do_search(2'b00, 2, -1);
        do_search(2'b01, 0, -1);
        reset_mid_emit();
        do_search(2'b01, 1, -1);
        abort_mid_scan();
        do_search(2'b11, 0, 4);
        for (int r = 0; r < 6; r++)
            do_search(2'($urandom_range(0, 3)), int'($urandom_range(0, 1)), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
